// File: rtl/pixmem_pkg.sv
// Shared types and helpers for the pixel-memory read arbiter.
package pixmem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    typedef logic [15:0] coord_t;

    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;
    localparam int IMG_C_DEF  = 3;
    localparam int NIB_SEL_DW = 256;

    // Pick the 4-bit pixel at nibble position nib out of a (zero-extended) memory word.
    function automatic logic [3:0] nib_sel(input logic [NIB_SEL_DW-1:0] word,
                                           input logic [5:0]            nib);
        return word[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/pixmem_arbiter_pix_index_calc.sv
// Combinational (x, y, z) -> linear pixel index with bounds check.
module pix_index_calc
    import pixmem_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int IMG_C = IMG_C_DEF
) (
    input  coord_t      x,
    input  coord_t      y,
    input  coord_t      z,
    output logic [31:0] idx,
    output logic        oob
);

    assign idx = (32'(z) * 32'(IMG_H) + 32'(y)) * 32'(IMG_W) + 32'(x);
    assign oob = (32'(x) >= 32'(IMG_W)) | (32'(y) >= 32'(IMG_H)) | (32'(z) >= 32'(IMG_C));

endmodule

// File: rtl/pixmem_arbiter.sv
// Round-robin arbiter sharing a single-port nibble-packed image memory
// between a CPU pixel port (requester 0) and a filter engine (requester 1).
module pixmem_arbiter
    import pixmem_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int IMG_C      = IMG_C_DEF,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  coord_t                x0,
    input  coord_t                y0,
    input  coord_t                z0,
    input  coord_t                x1,
    input  coord_t                y1,
    input  coord_t                z1,
    output logic [1:0]            ack,
    output logic [3:0]            p,
    output logic                  err,
    output logic                  csb,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  data_ready_mem
);

    localparam int PPW     = DATA_WIDTH / 4;
    localparam int LOG_PPW = $clog2(PPW);
    localparam int NIB_W   = (LOG_PPW > 0) ? LOG_PPW : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    rr_last_q, rr_last_d;
    coord_t                  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NIB_W-1:0]        nib_q, nib_d;
    logic                    csb_q, csb_d;
    logic [1:0]              ack_q, ack_d;
    logic [3:0]              p_q, p_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [31:0]             idx_s;
    logic                    oob_s;

    pix_index_calc #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .IMG_C (IMG_C)
    ) u_index (
        .x   (x_q),
        .y   (y_q),
        .z   (z_q),
        .idx (idx_s),
        .oob (oob_s)
    );

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state and next-output logic for the request/memory handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        addr_d    = addr_q;
        nib_d     = nib_q;
        csb_d     = 1'b1;
        ack_d     = 2'b00;
        p_d       = p_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // With both requesting, the one not served last wins.
                    if (req == 2'b11) begin
                        grant_d = ~rr_last_q;
                    end else begin
                        grant_d = req[1];
                    end
                    x_d     = grant_d ? x1 : x0;
                    y_d     = grant_d ? y1 : y0;
                    z_d     = grant_d ? z1 : z0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (oob_s) begin
                    ack_d[grant_q] = 1'b1;
                    p_d            = 4'h0;
                    err_d          = 1'b1;
                    state_d        = RESP;
                end else begin
                    addr_d  = ADDR_WIDTH'(32'(BASE_ADDR) + (idx_s >> LOG_PPW));
                    nib_d   = NIB_W'(idx_s % 32'(PPW));
                    csb_d   = 1'b0;
                    cnt_d   = CNT_W'(0);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc_s;
                // Data arriving on the final allowed cycle still wins over the timeout.
                if (data_ready_mem) begin
                    ack_d[grant_q] = 1'b1;
                    p_d            = nib_sel(NIB_SEL_DW'(data_out), 6'(nib_q));
                    err_d          = 1'b0;
                    state_d        = RESP;
                end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
                    ack_d[grant_q] = 1'b1;
                    p_d            = 4'h0;
                    err_d          = 1'b1;
                    state_d        = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                rr_last_d = grant_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            x_q       <= 16'h0000;
            y_q       <= 16'h0000;
            z_q       <= 16'h0000;
            addr_q    <= '0;
            nib_q     <= '0;
            csb_q     <= 1'b1;
            ack_q     <= 2'b00;
            p_q       <= 4'h0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            addr_q    <= addr_d;
            nib_q     <= nib_d;
            csb_q     <= csb_d;
            ack_q     <= ack_d;
            p_q       <= p_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack  = ack_q;
    assign p    = p_q;
    assign err  = err_q;
    assign csb  = csb_q;
    assign we   = 1'b0;
    assign addr = addr_q;

endmodule

// File: tb/tb_pixmem_arbiter.sv
// Scoreboard bench for pixmem_arbiter: directed cases plus randomized traffic.
module tb_pixmem_arbiter;
    import pixmem_pkg::*;

    typedef struct {
        int         id;
        logic [3:0] p;
        logic       err;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst;
    logic        req0_s, req1_s;
    logic [1:0]  req;
    coord_t      x0, y0, z0, x1, y1, z1;
    logic [1:0]  ack;
    logic [3:0]  p;
    logic        err, csb, we;
    logic [15:0] addr;
    logic [31:0] data_out;
    logic        data_ready_mem;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          csb_low_cnt = 0;
    int          csb_low_cyc = -1;
    logic [15:0] csb_addr = 16'h0;
    exp_t        sb[$];
    int          model_last = 1;
    int          mem_delay  = 1;
    int          cx[2][8];
    int          cy[2][8];
    int          cz[2][8];

    assign req = {req1_s, req0_s};

    pixmem_arbiter dut (
        .clock(clock), .rst(rst), .req(req),
        .x0(x0), .y0(y0), .z0(z0), .x1(x1), .y1(y1), .z1(z1),
        .ack(ack), .p(p), .err(err), .csb(csb), .we(we), .addr(addr),
        .data_out(data_out), .data_ready_mem(data_ready_mem)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'd528) return 32'hFEDC_BA98;
        else return ({16'h0000, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Reference: bounds, linear index, word/nibble split; data arriving in WAIT cycle d<=15 succeeds.
    function automatic exp_t model_exp(input int id, input int x, input int y, input int z,
                                       input int delay);
        exp_t        e;
        int          idx;
        logic [31:0] w;
        e.id = id;
        if (x >= 64 || y >= 64 || z >= 3) begin
            e.p = 4'h0; e.err = 1'b1;
        end else if (delay < 1 || delay > 15) begin
            e.p = 4'h0; e.err = 1'b1;
        end else begin
            idx   = (z * 64 + y) * 64 + x;
            w     = mem_word(16'(idx / 8));
            e.p   = 4'((w >> (4 * (idx % 8))) & 32'hF);
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input int id, input int x, input int y, input int z, input int delay);
        sb.push_back(model_exp(id, x, y, z, delay));
        model_last = id;
    endtask

    // Memory model: answers a csb-low cycle mem_delay cycles later (0 = never).
    initial begin
        bit          pending = 1'b0;
        int          pend_left = 0;
        logic [15:0] pend_addr = 16'h0;
        data_ready_mem = 1'b0;
        data_out       = 32'h0;
        forever begin
            @(negedge clock);
            data_ready_mem = 1'b0;
            data_out       = $urandom;
            if (rst === 1'b1) pending = 1'b0;
            if (pending) begin
                if (pend_left == 0) begin
                    data_ready_mem = 1'b1;
                    data_out       = mem_word(pend_addr);
                    pending        = 1'b0;
                end else begin
                    pend_left--;
                end
            end
            if (csb === 1'b0 && mem_delay > 0) begin
                pending   = 1'b1;
                pend_addr = addr;
                pend_left = mem_delay - 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and tracks memory selects.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (csb === 1'b0) begin
                csb_low_cnt++;
                csb_low_cyc = cyc;
                csb_addr    = addr;
                chk("we_low", we, 1'b0);
            end
            if (rst === 1'b0 && ack !== 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", ack, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("ack_id", ack, (e.id == 1) ? 2'b10 : 2'b01);
                    chk("p", p, e.p);
                    chk("err", err, e.err);
                end
            end
        end
    end

    task automatic wait_ack(input int id, output int at);
        at = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (ack[id] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_wait", 1'b0, 1'b1);
    endtask

    // Requester: holds req across n back-to-back transactions, new coordinates after each ack.
    task automatic run_req(input int id, input int n, output int c0, output int at);
        @(posedge clock); #1;
        c0 = cyc;
        at = -1;
        for (int i = 0; i < n; i++) begin
            if (id == 0) begin
                x0 = 16'(cx[0][i]); y0 = 16'(cy[0][i]); z0 = 16'(cz[0][i]); req0_s = 1'b1;
            end else begin
                x1 = 16'(cx[1][i]); y1 = 16'(cy[1][i]); z1 = 16'(cz[1][i]); req1_s = 1'b1;
            end
            wait_ack(id, at);
            @(posedge clock); #1;
        end
        if (id == 0) req0_s = 1'b0;
        else req1_s = 1'b0;
    endtask

    task automatic single(input int id, input int x, input int y, input int z,
                          output int c0, output int at);
        cx[id][0] = x; cy[id][0] = y; cz[id][0] = z;
        run_req(id, 1, c0, at);
    endtask

    initial begin
        int   c0, at, ca, cb, aa, ab, n0;
        exp_t e;
        rst = 1'b1;
        req0_s = 1'b0; req1_s = 1'b0;
        x0 = 16'h0; y0 = 16'h0; z0 = 16'h0; x1 = 16'h0; y1 = 16'h0; z1 = 16'h0;
        #2;
        chk("rst_csb", csb, 1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_addr", addr, 16'h0);
        chk("rst_ack", ack, 2'b00);
        chk("rst_p", p, 4'h0);
        chk("rst_err", err, 1'b0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        model_last = 1;

        // Single CPU read
        mem_delay = 1;
        n0 = csb_low_cnt;
        e.id = 0; e.p = 4'hD; e.err = 1'b0;
        sb.push_back(e);
        model_last = 0;
        single(0, 5, 2, 1, c0, at);
        chk("cpu_latency", at - c0, 4);
        chk("cpu_csb_count", csb_low_cnt - n0, 1);
        chk("cpu_csb_cycle", csb_low_cyc - c0, 2);
        chk("cpu_addr", csb_addr, 16'd528);
        chk("p_hold", p, 4'hD);

        // Out of bounds: no memory access, ack two cycles after request
        n0 = csb_low_cnt;
        push_exp(1, 64, 0, 0, 1);
        single(1, 64, 0, 0, c0, at);
        chk("oob_latency", at - c0, 2);
        chk("oob_csb_count", csb_low_cnt - n0, 0);

        // Far corner pixel
        mem_delay = 3;
        push_exp(0, 63, 63, 2, 3);
        single(0, 63, 63, 2, c0, at);
        chk("corner_addr", csb_addr, 16'd1535);
        chk("corner_latency", at - c0, 6);

        // Timeout, then a late strobe that must be ignored
        mem_delay = 20;
        n0 = csb_low_cnt;
        push_exp(1, 10, 20, 1, 20);
        single(1, 10, 20, 1, c0, at);
        chk("tmo_latency", at - c0, 18);
        chk("tmo_csb_count", csb_low_cnt - n0, 1);
        repeat (12) @(posedge clock);

        // Reset in the middle of WAIT
        mem_delay = 0;
        @(posedge clock); #1;
        x0 = 16'd7; y0 = 16'd8; z0 = 16'd0; req0_s = 1'b1;
        repeat (4) @(posedge clock);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_csb", csb, 1'b1);
        chk("rst_mid_ack", ack, 2'b00);
        req0_s = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        model_last = 1;
        repeat (10) @(posedge clock);

        // Both request after reset: requester 0 first, acks five cycles apart
        mem_delay = 1;
        cx[0][0] = 3;  cy[0][0] = 4;  cz[0][0] = 0;
        cx[1][0] = 40; cy[1][0] = 50; cz[1][0] = 2;
        for (int k = 0; k < 2; k++) begin
            int id;
            id = (model_last == 0) ? 1 : 0;
            push_exp(id, cx[id][0], cy[id][0], cz[id][0], 1);
        end
        fork
            run_req(0, 1, ca, aa);
            run_req(1, 1, cb, ab);
        join
        chk("post_rst_first", aa - ca, 4);
        chk("post_rst_spacing", ab - aa, 5);

        // Sustained contention with random in-bounds coordinates
        for (int i = 0; i < 4; i++) begin
            for (int id = 0; id < 2; id++) begin
                cx[id][i] = $urandom_range(0, 63);
                cy[id][i] = $urandom_range(0, 63);
                cz[id][i] = $urandom_range(0, 2);
            end
        end
        begin
            int nxt[2];
            nxt[0] = 0; nxt[1] = 0;
            for (int k = 0; k < 8; k++) begin
                int id;
                id = (model_last == 0) ? 1 : 0;
                push_exp(id, cx[id][nxt[id]], cy[id][nxt[id]], cz[id][nxt[id]], 1);
                nxt[id]++;
            end
        end
        fork
            run_req(0, 4, ca, aa);
            run_req(1, 4, cb, ab);
        join

        // Randomized single requests with occasional out-of-bounds and slow memory
        for (int i = 0; i < 40; i++) begin
            int id, x, y, z, d;
            id = $urandom_range(0, 1);
            x  = ($urandom_range(0, 7) == 0) ? $urandom_range(64, 65535) : $urandom_range(0, 63);
            y  = ($urandom_range(0, 7) == 0) ? $urandom_range(64, 65535) : $urandom_range(0, 63);
            z  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 65535) : $urandom_range(0, 2);
            d  = (i % 10 == 3) ? 15 : (i % 10 == 7) ? 16 : $urandom_range(1, 17);
            mem_delay = d;
            push_exp(id, x, y, z, d);
            single(id, x, y, z, c0, at);
        end

        repeat (5) @(posedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
